special_seq_monitor: RTL and testbench
======================================

# special_seq_monitor

Downstream checker for the 3-bit special counter. Samples the counter's `q` bus every clock and compares it against a programmed cyclic sequence. Acquires lock after a run of correct steps, flags each step error and keeps a saturating error count. Sits between the counter and the board-level status LEDs and display.

## Interface
Parameters:
- `SEQ_LEN`, 6: number of valid sequence entries (2..8).
- `SEQ`, entries {0,1,3,7,6,4,0,0}: 24-bit table.
  - Entry i is `SEQ[3i+2:3i]`.
  - Entry 0 is the first value.
  - Entries at index ≥ `SEQ_LEN` are ignored.
- `LOCK_N`, 3: consecutive correct values needed to lock (1..7).

Ports:
- `clk` input 1: rising-edge clock, same clock as the counter.
- `rst_n` input 1: asynchronous, active-low reset.
- `q` input 3: counter value to monitor.
- `clr` input 1: synchronous clear of error count and lock.
- `locked` output 1: sequence tracked and in lock.
- `err_pulse` output 1: one-cycle pulse on a step error while locked.
- `err_cnt` output 8: saturating error count.
- `pos` output 3: table index of the last sampled value; valid only when `locked`=1, else 0.
- `wrap_pulse` output 1: one-cycle pulse when entry `SEQ_LEN-1` is followed by entry 0 while locked.

## Operation
- Stage 1: `q` is registered into `q_r` on every rising edge.
- Stage 2: the FSM compares `q_r` with the expected entry `exp_idx`.
- FSM states: HUNT, SYNC, LOCKED.
- HUNT:
  - Search the table for `q_r`, lowest matching index k wins.
  - Found: `exp_idx` ← (k+1) mod `SEQ_LEN`, `run` ← 1, then go to SYNC, or straight to LOCKED if `LOCK_N`=1.
  - Not found: stay in HUNT.
- SYNC:
  - `q_r` equals entry `exp_idx`: advance `exp_idx` (wrapping at `SEQ_LEN`) and increment `run`. When `run` reaches `LOCK_N`, go to LOCKED.
  - Mismatch: perform the HUNT search on this same `q_r` in this cycle, no idle cycle. Found: `run`=1 and stay in SYNC. Not found: go to HUNT. No error is counted.
- LOCKED:
  - Match: advance `exp_idx`, and `pos` ← matched index. A match at index 0 whose previous index was `SEQ_LEN-1` asserts `wrap_pulse`.
  - Mismatch: `err_pulse`=1, `err_cnt` increments, `locked` ← 0, `pos` ← 0, go to HUNT. The offending `q_r` is not re-searched.
- `err_cnt` saturates at 255; further errors still pulse `err_pulse` but do not increment.
- `clr`:
  - Forces HUNT, `run`=0, `err_cnt`=0, `locked`=0, `pos`=0.
  - Suppresses `err_pulse` and `wrap_pulse` in that cycle.
  - Takes priority over any simultaneous compare result.
  - Does not affect `q_r`.
- Reset (asynchronous, any time including mid-lock):
  - `q_r`=0, state HUNT, `exp_idx`=0, `run`=0.
  - All outputs 0.

## Timing
- All outputs are registered; no combinational path from `q` to any output.
- Latency: a value on `q` at edge N is compared at edge N+1. Resulting `locked`, `err_pulse`, `wrap_pulse`, `pos` and `err_cnt` are visible after edge N+1, i.e. 2 cycles from input.
- Lock time from reset with a correct sequence: the first value is found at edge 2, so `locked` rises after edge `LOCK_N`+1.
- `err_pulse` and `wrap_pulse` are exactly one cycle wide.
- `clr` sampled at edge M takes effect at edge M.
- Reset deassertion needs no synchronizer inside this block; it is handled at the top level.

## Configuration
- `SEQ_MON_SEG_EN` defined:
  - Adds output `seg` (7 bits, active-low, bit order a..g = bit 0..6).
  - `seg` is a registered 7-segment decode of `q_r`, digits 0..7.
  - `seg` is updated each edge, giving 2-cycle latency from `q`.
  - Reset value of `seg` is 7'h7F (blank).
- `SEQ_MON_SEG_EN` undefined: no `seg` port and no decode logic. All other behaviour is identical.

## Test plan
- Reset, then drive 0,1,3,7,6,4 repeating → `locked`=1 after edge 4. `pos` follows 2,3,4,5,0,1… `wrap_pulse` fires once per cycle, when `pos` goes 5→0. `err_cnt`=0.
- Locked, inject 5 in place of 6 → one-cycle `err_pulse`, `err_cnt`=1, `locked`=0. Resume the correct sequence → relock after 3 correct values.
- Start with 2, 5, 2 (values not in the table), then a correct sequence → HUNT holds and `locked` stays 0 until 3 consecutive correct values.
- Force 300 errors (alternate lock and a bad value) → `err_cnt` stops at 255, and `err_pulse` keeps pulsing.
- Assert `clr` in the same cycle as a mismatch → no `err_pulse`, `err_cnt`=0, state HUNT. Assert `rst_n`=0 mid-lock → all outputs 0 immediately.
- With `SEQ_MON_SEG_EN` defined, drive `q`=7 → after 2 edges `seg`=7'b1111000. Under reset, `seg`=7'h7F.

Source files
------------

// File: rtl/special_seq_monitor.sv
// Checks a 3-bit counter's q bus against a programmed cyclic sequence, tracks lock and counts step errors.
// Optional 7-segment decode of the sampled value is enabled by defining SEQ_MON_SEG_EN.
module special_seq_monitor #(
  parameter int          SEQ_LEN = 6,
  parameter logic [23:0] SEQ     = {3'd0, 3'd0, 3'd4, 3'd6, 3'd7, 3'd3, 3'd1, 3'd0},
  parameter int          LOCK_N  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] q,
  input  logic       clr,
  output logic       locked,
  output logic       err_pulse,
  output logic [7:0] err_cnt,
`ifdef SEQ_MON_SEG_EN
  output logic [6:0] seg,
`endif
  output logic [2:0] pos,
  output logic       wrap_pulse
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'(SEQ_LEN - 1);
  localparam logic [2:0] LOCK_RUN = 3'(LOCK_N);

  state_t     state;
  logic [2:0] q_r;
  logic [2:0] exp_idx;
  logic [2:0] run;
  logic [2:0] exp_val;
  logic       hit_found;
  logic [2:0] hit_idx;
  logic       match;

  function automatic logic [2:0] next_idx(input logic [2:0] idx);
    next_idx = (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
  endfunction

`ifdef SEQ_MON_SEG_EN
  // Active-low segments, bit 0 = a ... bit 6 = g
  function automatic logic [6:0] seg_decode(input logic [2:0] v);
    case (v)
      3'd0:    seg_decode = 7'h40;
      3'd1:    seg_decode = 7'h79;
      3'd2:    seg_decode = 7'h24;
      3'd3:    seg_decode = 7'h30;
      3'd4:    seg_decode = 7'h19;
      3'd5:    seg_decode = 7'h12;
      3'd6:    seg_decode = 7'h02;
      3'd7:    seg_decode = 7'h78;
      default: seg_decode = 7'h7F;
    endcase
  endfunction
`endif

  // Expected table entry and lowest-index table search for the sampled value
  always_comb begin
    exp_val   = 3'd0;
    hit_found = 1'b0;
    hit_idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      exp_val = (exp_idx == 3'(i)) ? SEQ[3*i +: 3] : exp_val;
    end
    // Descending scan so the lowest matching index is the last one written
    for (int i = 7; i >= 0; i--) begin
      hit_found = ((i < SEQ_LEN) && (SEQ[3*i +: 3] == q_r)) ? 1'b1  : hit_found;
      hit_idx   = ((i < SEQ_LEN) && (SEQ[3*i +: 3] == q_r)) ? 3'(i) : hit_idx;
    end
    match = (q_r == exp_val);
  end

  // Input sample stage, tracking FSM and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r        <= 3'd0;
      state      <= HUNT;
      exp_idx    <= 3'd0;
      run        <= 3'd0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_cnt    <= 8'd0;
      pos        <= 3'd0;
      wrap_pulse <= 1'b0;
    end else begin
      q_r        <= q;
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
      if (clr) begin
        state   <= HUNT;
        exp_idx <= 3'd0;
        run     <= 3'd0;
        err_cnt <= 8'd0;
        locked  <= 1'b0;
        pos     <= 3'd0;
      end else begin
        case (state)
          HUNT: begin
            if (hit_found) begin
              exp_idx <= next_idx(hit_idx);
              run     <= 3'd1;
              if (LOCK_N == 1) begin
                state  <= LOCKED;
                locked <= 1'b1;
                pos    <= hit_idx;
              end else begin
                state  <= SYNC;
              end
            end else begin
              state <= HUNT;
            end
          end
          SYNC: begin
            if (match) begin
              exp_idx <= next_idx(exp_idx);
              run     <= run + 3'd1;
              if ((run + 3'd1) == LOCK_RUN) begin
                state  <= LOCKED;
                locked <= 1'b1;
                pos    <= exp_idx;
              end else begin
                state  <= SYNC;
              end
            end else if (hit_found) begin
              // Re-acquire on the same sample without an idle cycle
              exp_idx <= next_idx(hit_idx);
              run     <= 3'd1;
              state   <= SYNC;
            end else begin
              run     <= 3'd0;
              state   <= HUNT;
            end
          end
          LOCKED: begin
            if (match) begin
              exp_idx    <= next_idx(exp_idx);
              pos        <= exp_idx;
              wrap_pulse <= (exp_idx == 3'd0);
            end else begin
              err_pulse <= 1'b1;
              err_cnt   <= (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
              locked    <= 1'b0;
              pos       <= 3'd0;
              run       <= 3'd0;
              state     <= HUNT;
            end
          end
          default: begin
            state   <= HUNT;
            run     <= 3'd0;
            locked  <= 1'b0;
            pos     <= 3'd0;
          end
        endcase
      end
    end
  end

`ifdef SEQ_MON_SEG_EN
  // Display decode of the sampled value, one stage behind q_r
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= 7'h7F;
    end else begin
      seg <= seg_decode(q_r);
    end
  end
`endif

endmodule

// File: tb/tb_special_seq_monitor.sv
// Scoreboard bench for special_seq_monitor: a behavioural model predicts each cycle's outputs,
// a separate monitor pops and compares them one time unit after every rising edge.
module tb_special_seq_monitor;

  typedef struct packed {
    logic       lk;
    logic       ep;
    logic       wp;
    logic [2:0] ps;
    logic [7:0] cnt;
    logic [6:0] sg;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] q = 3'd0;
  logic       clr = 1'b0;
  logic       locked;
  logic       err_pulse;
  logic [7:0] err_cnt;
  logic [2:0] pos;
  logic       wrap_pulse;
  logic [6:0] seg_v;

  int vectors = 0;
  int miscompares = 0;
  exp_t exp_q[$];

  special_seq_monitor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .q          (q),
    .clr        (clr),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_cnt    (err_cnt),
`ifdef SEQ_MON_SEG_EN
    .seg        (seg_v),
`endif
    .pos        (pos),
    .wrap_pulse (wrap_pulse)
  );

`ifndef SEQ_MON_SEG_EN
  assign seg_v = 7'h7F;
`endif

  always #5 clk = ~clk;

  // Reference model: sequence table, lock rule and saturating counter in plain integers
  int tbl [8] = '{0, 1, 3, 7, 6, 4, 0, 0};
  int seg_tbl [8] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78};
  localparam int L  = 6;
  localparam int LN = 3;
  bit m_lock, m_track;
  int m_want, m_streak, m_cnt, m_pos, m_qr, m_seg;

  function automatic int search(input int v);
    for (int i = 0; i < L; i++) if (tbl[i] == v) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_lock = 0; m_track = 0; m_want = 0; m_streak = 0;
    m_cnt = 0; m_pos = 0; m_qr = 0; m_seg = 'h7F;
  endtask

  // One clock of the model: compare the previously sampled value, then sample qv
  task automatic model_step(input int qv, input bit c, output exp_t e);
    int k;
    bit ep = 0, wp = 0;
    if (c) begin
      m_lock = 0; m_track = 0; m_streak = 0; m_cnt = 0; m_pos = 0; m_want = 0;
    end else if (m_lock) begin
      if (tbl[m_want] == m_qr) begin
        m_pos = m_want;
        wp = (m_want == 0);
        m_want = (m_want + 1) % L;
      end else begin
        ep = 1;
        if (m_cnt < 255) m_cnt++;
        m_lock = 0; m_track = 0; m_streak = 0; m_pos = 0;
      end
    end else if (m_track && tbl[m_want] == m_qr) begin
      m_streak++;
      if (m_streak == LN) begin m_lock = 1; m_pos = m_want; end
      m_want = (m_want + 1) % L;
    end else begin
      k = search(m_qr);
      if (k >= 0) begin
        m_track = 1; m_streak = 1; m_want = (k + 1) % L;
        if (LN == 1) begin m_lock = 1; m_pos = k; end
      end else begin
        m_track = 0; m_streak = 0;
      end
    end
    m_seg = seg_tbl[m_qr];
    m_qr = qv;
    e.lk = m_lock; e.ep = ep; e.wp = wp;
    e.ps = 3'(m_pos); e.cnt = 8'(m_cnt); e.sg = 7'(m_seg);
  endtask

  // Drive one cycle of stimulus (called at a falling edge) and queue the expected outcome
  task automatic step(input int qv, input bit c);
    exp_t e;
    q = 3'(qv);
    clr = c;
    model_step(qv, c, e);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic check_out(input string name, input exp_t e);
    bit ok;
    vectors++;
    ok = (locked === e.lk) && (err_pulse === e.ep) && (wrap_pulse === e.wp) &&
         (pos === e.ps) && (err_cnt === e.cnt);
`ifdef SEQ_MON_SEG_EN
    ok = ok && (seg_v === e.sg);
`endif
    if (!ok) begin
      miscompares++;
      $display("FAIL %s t=%0t got lk=%b ep=%b wp=%b pos=%0d cnt=%0d seg=%h need lk=%b ep=%b wp=%b pos=%0d cnt=%0d seg=%h",
               name, $time, locked, err_pulse, wrap_pulse, pos, err_cnt, seg_v,
               e.lk, e.ep, e.wp, e.ps, e.cnt, e.sg);
    end
  endtask

  // Asynchronous reset applied at a falling edge; outputs must clear without a clock edge
  task automatic do_reset();
    exp_t z;
    rst_n = 1'b0;
    #1;
    z = '{lk: 1'b0, ep: 1'b0, wp: 1'b0, ps: 3'd0, cnt: 8'd0, sg: 7'h7F};
    check_out("async_reset", z);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Monitor: every cycle's expectation is compared just after the rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_out("cycle", e);
      end
    end
  end

  initial begin
    int si;
    model_reset();
    @(negedge clk);
    do_reset();

    // Correct sequence from reset
    for (int i = 0; i < 18; i++) step(tbl[i % L], 1'b0);
    // Inject 5 in place of 6, then resume with 4,0,1,3,...
    step(0, 1'b0); step(1, 1'b0); step(3, 1'b0); step(7, 1'b0);
    step(5, 1'b0);
    for (int i = 5; i < 17; i++) step(tbl[i % L], 1'b0);
    // Values absent from the table, then a correct run
    step(2, 1'b0); step(5, 1'b0); step(2, 1'b0);
    for (int i = 0; i < 8; i++) step(tbl[i % L], 1'b0);
    // 300 forced errors to saturate the counter
    for (int n = 0; n < 300; n++) begin
      step(0, 1'b0); step(1, 1'b0); step(3, 1'b0); step(5, 1'b0);
    end
    step(0, 1'b0); step(1, 1'b0); step(3, 1'b0); step(7, 1'b0);
    // Mismatch compared in the same cycle as clr
    step(2, 1'b0);
    step(6, 1'b1);
    step(4, 1'b0); step(0, 1'b0);
    // Relock, then reset mid-lock
    for (int i = 0; i < 8; i++) step(tbl[i % L], 1'b0);
    do_reset();
    // Randomised: mostly-correct sequence with glitches, jumps and occasional clr
    si = 0;
    for (int n = 0; n < 3000; n++) begin
      int r, v;
      bit c;
      r = $urandom_range(0, 99);
      if (r < 82) begin
        v = tbl[si]; si = (si + 1) % L;
      end else if (r < 92) begin
        v = $urandom_range(0, 7);
      end else begin
        si = $urandom_range(0, L - 1); v = tbl[si]; si = (si + 1) % L;
      end
      c = ($urandom_range(0, 59) == 0);
      step(v, c);
      if (n == 1500) do_reset();
    end

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expectations left, need 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
